imply: RTL and testbench

//  Boolean constraint propagation across one LUT node of the SAT circuit.

---
 rtl/imply_pkg.sv | 13 +
 rtl/imply_row_match.sv | 21 ++
 rtl/imply.sv | 52 +++++
 tb/tb_imply.sv | 112 +++++++++++
 4 files changed

// File: rtl/imply_pkg.sv
// imply_pkg: three-valued pin encoding shared by the imply LUT propagator
package imply_pkg;
   typedef logic [1:0] pin_t;
   localparam pin_t PIN_ZERO    = 2'b00;
   localparam pin_t PIN_ONE     = 2'b10;
   localparam pin_t PIN_UNKNOWN = 2'b11;
   function automatic logic pin_known(input pin_t p);
      return ~p[0];
   endfunction
   function automatic logic pin_value(input pin_t p);
      return p[1];
   endfunction
endpackage

// File: rtl/imply_row_match.sv
// imply_row_match: flags every truth-table row consistent with the known pins
module imply_row_match
   import imply_pkg::*;
#(
   parameter int LUT_SIZE = 8
) (
   input  logic [2*LUT_SIZE+1:0]    pins,
   input  logic [(1<<LUT_SIZE)-1:0] tt,
   output logic [(1<<LUT_SIZE)-1:0] mask
);
   localparam int TTB = 1 << LUT_SIZE;
   for (genvar a = 0; a < TTB; a++) begin : g_row
      localparam logic [LUT_SIZE-1:0] ADDR = LUT_SIZE'(a);
      logic [LUT_SIZE:0] ok;
      for (genvar i = 0; i < LUT_SIZE; i++) begin : g_in
         assign ok[i] = !pin_known(pins[2*i+:2]) || (pin_value(pins[2*i+:2]) == ADDR[i]);
      end
      assign ok[LUT_SIZE] = !pin_known(pins[2*LUT_SIZE+:2]) || (pin_value(pins[2*LUT_SIZE+:2]) == tt[a]);
      assign mask[a] = &ok;
   end
endmodule

// File: rtl/imply.sv
// imply: registered constraint propagation across one LUT node
module imply
   import imply_pkg::*;
#(
   parameter int LUT_SIZE = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic [2*LUT_SIZE+1:0]    pins,
   input  logic [(1<<LUT_SIZE)-1:0] tt,
   output logic                     out_valid,
   output logic [2*LUT_SIZE+1:0]    implied_pins,
   output logic                     conflict
);
   localparam int TTB = 1 << LUT_SIZE;
   // Column i of the address space: bit a is a[i]
   function automatic logic [TTB-1:0] addr_col(input int i);
      for (int a = 0; a < TTB; a++) addr_col[a] = a[i];
   endfunction
   logic [TTB-1:0] mask;
   logic [LUT_SIZE:0] has0, has1;
   logic [2*LUT_SIZE+1:0] next_pins;
   imply_row_match #(.LUT_SIZE(LUT_SIZE)) u_row_match (
      .pins(pins),
      .tt  (tt),
      .mask(mask)
   );
   // With no consistent row, pins are echoed with 01 normalised to UNKNOWN
   always_comb begin
      for (int i = 0; i < LUT_SIZE; i++) begin
         has1[i] = |(mask & addr_col(i));
         has0[i] = |(mask & ~addr_col(i));
      end
      has1[LUT_SIZE] = |(mask & tt);
      has0[LUT_SIZE] = |(mask & ~tt);
      for (int i = 0; i <= LUT_SIZE; i++)
         next_pins[2*i+:2] = |mask ? {has1[i], has0[i] & has1[i]}
                                   : (pin_known(pins[2*i+:2]) ? pins[2*i+:2] : PIN_UNKNOWN);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         conflict     <= 1'b0;
         implied_pins <= '1;
      end else begin
         out_valid    <= in_valid;
         conflict     <= ~|mask;
         implied_pins <= next_pins;
      end
   end
endmodule

// File: tb/tb_imply.sv
// tb_imply: directed vectors for the imply LUT propagator
module tb_imply;
   import imply_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic [17:0] pins = '1;
   logic [255:0] tt = '0;
   logic out_valid;
   logic [17:0] implied_pins;
   logic conflict;
   int checks = 0;
   int errors = 0;
   logic [255:0] tt_p0, tt_and;
   logic [17:0] p, e;

   imply #(.LUT_SIZE(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .pins        (pins),
      .tt          (tt),
      .out_valid   (out_valid),
      .implied_pins(implied_pins),
      .conflict    (conflict)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [17:0] pv(input pin_t p0, input pin_t p1, input pin_t po);
      pv = '1;
      pv[1:0] = p0;
      pv[3:2] = p1;
      pv[17:16] = po;
   endfunction

   task automatic step(input logic v, input logic r, input logic [17:0] pp, input logic [255:0] t);
      @(negedge clk);
      in_valid = v;
      rst_n = r;
      pins = pp;
      tt = t;
      @(posedge clk);
      #1;
   endtask

   task automatic run(input string tag, input logic [17:0] pp, input logic [255:0] t,
                      input logic [17:0] exp_pins, input logic exp_conf);
      step(1'b1, 1'b1, pp, t);
      check({tag, "_pins"}, 32'(implied_pins), 32'(exp_pins));
      check({tag, "_conf"}, 32'(conflict), 32'(exp_conf));
      check({tag, "_vld"}, 32'(out_valid), 32'd1);
   endtask

   initial begin
      for (int a = 0; a < 256; a++) begin
         tt_p0[a] = a[0];
         tt_and[a] = a[0] & a[1];
      end
      step(1'b1, 1'b0, '1, '0);
      step(1'b1, 1'b0, '1, '0);
      check("rst_pins", 32'(implied_pins), 32'h3FFFF);
      check("rst_vld", 32'(out_valid), 32'd0);
      check("rst_conf", 32'(conflict), 32'd0);

      run("tt0", '1, '0, 18'h0FFFF, 1'b0);
      p = '1;
      p[7:6] = 2'b01;
      run("tt0_in3_01", p, '0, 18'h0FFFF, 1'b0);
      run("tt1", '1, '1, 18'h2FFFF, 1'b0);
      run("p0_unk", '1, tt_p0, 18'h3FFFF, 1'b0);
      run("p0_in0z", pv(PIN_ZERO, PIN_UNKNOWN, PIN_UNKNOWN), tt_p0,
          pv(PIN_ZERO, PIN_UNKNOWN, PIN_ZERO), 1'b0);
      run("p0_in0o", pv(PIN_ONE, PIN_UNKNOWN, PIN_UNKNOWN), tt_p0,
          pv(PIN_ONE, PIN_UNKNOWN, PIN_ONE), 1'b0);
      run("and_in0z", pv(PIN_ZERO, PIN_UNKNOWN, PIN_UNKNOWN), tt_and,
          pv(PIN_ZERO, PIN_UNKNOWN, PIN_ZERO), 1'b0);
      run("and_in01o", pv(PIN_ONE, PIN_ONE, PIN_UNKNOWN), tt_and,
          pv(PIN_ONE, PIN_ONE, PIN_ONE), 1'b0);
      run("and_outo", pv(PIN_UNKNOWN, PIN_UNKNOWN, PIN_ONE), tt_and,
          pv(PIN_ONE, PIN_ONE, PIN_ONE), 1'b0);
      run("and_in0o_outz", pv(PIN_ONE, PIN_UNKNOWN, PIN_ZERO), tt_and,
          pv(PIN_ONE, PIN_ZERO, PIN_ZERO), 1'b0);
      p = pv(PIN_ZERO, PIN_UNKNOWN, PIN_ONE);
      p[11:10] = 2'b01;
      e = pv(PIN_ZERO, PIN_UNKNOWN, PIN_ONE);
      run("and_conflict", p, tt_and, e, 1'b1);

      step(1'b1, 1'b0, pv(PIN_ZERO, PIN_UNKNOWN, PIN_UNKNOWN), tt_and);
      check("midrst_vld", 32'(out_valid), 32'd0);
      check("midrst_pins", 32'(implied_pins), 32'h3FFFF);
      check("midrst_conf", 32'(conflict), 32'd0);
      step(1'b0, 1'b1, '1, '0);
      check("idle_vld", 32'(out_valid), 32'd0);
      check("idle_pins", 32'(implied_pins), 32'h0FFFF);
      step(1'b1, 1'b1, '1, '0);
      check("pulse_vld_hi", 32'(out_valid), 32'd1);
      step(1'b0, 1'b1, '1, '0);
      check("pulse_vld_lo", 32'(out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
